// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//   Hazard and forwarding control for a 5-stage MIPS-style pipeline. Keeps a shadow copy of the
//   destination/RegWrite/MemRead of the instructions in EX and MEM, and from it derives the EX
//   forwarding selects, the ID-stage compare forwarding, the load-use / branch / jr stall, and
//   the PC/IF-ID enables and flush. Counts inserted bubbles in a saturating counter.
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   id_*                  decoded fields of the instruction currently in ID
//   fwd_a, fwd_b          registered EX operand selects: 0 regfile, 1 EX/MEM, 2 MEM/WB
//   fwd_id_a, fwd_id_b    ID comparator operands taken from the EX/MEM ALU result
//   ctrl_pass             1 pass control unit outputs into ID/EX, 0 insert bubble
//   pc_write, ifid_write  PC and IF/ID load enables
//   ifid_flush            zero IF/ID on the next edge (taken redirect)
//   stall_count           saturating count of bubbles inserted since reset
module hazard_forward_ctrl #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_branch,
  input  logic             id_jr,
  input  logic             id_redirect,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_id_a,
  output logic             fwd_id_b,
  output logic             ctrl_pass,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count
);

  // Shadow EX and MEM entries. The WB entry is not kept: WB results reach ID through the
  // write-before-read register file and EX via the MEM entry's select computed a cycle earlier.
  logic [REG_W-1:0] e_dest_q, m_dest_q;
  logic             e_rw_q, e_mr_q, m_rw_q, m_mr_q;

  logic             stall;
  logic             load_use, br_haz, jr_haz;
  logic             e_rs, e_rt, m_rs, m_rt;
  logic [1:0]       fwd_a_d, fwd_b_d;

  // Register $0 is hardwired, so it never matches a producer.
  function automatic logic match(input logic [REG_W-1:0] d, input logic [REG_W-1:0] r);
    return (d != '0) && (d == r);
  endfunction

  always_comb begin
    e_rs = match(e_dest_q, id_rs);
    e_rt = match(e_dest_q, id_rt);
    m_rs = match(m_dest_q, id_rs);
    m_rt = match(m_dest_q, id_rt);

    load_use = e_mr_q && (e_rs || (id_uses_rt && e_rt));
    // Branch/jr compare in ID: any ALU result still in EX, or a load still in MEM, is not ready.
    br_haz   = id_branch && ((e_rw_q && (e_rs || e_rt)) || (m_mr_q && (m_rs || m_rt)));
    jr_haz   = id_jr && ((e_rw_q && e_rs) || (m_mr_q && m_rs));
    stall    = id_valid && (load_use || br_haz || jr_haz);
  end

  // Select for the instruction about to enter EX: nearest producer wins.
  always_comb begin
    fwd_a_d = 2'd0;
    fwd_b_d = 2'd0;
    if (!stall) begin
      if (e_rw_q && e_rs)      fwd_a_d = 2'd1;
      else if (m_rw_q && m_rs) fwd_a_d = 2'd2;
      if (e_rw_q && e_rt)      fwd_b_d = 2'd1;
      else if (m_rw_q && m_rt) fwd_b_d = 2'd2;
    end
  end

  always_comb begin
    ctrl_pass  = !stall;
    pc_write   = !stall;
    ifid_write = !stall;
    ifid_flush = !stall && id_redirect;
    // A load in MEM has no result on the ALU path yet; that case is covered by the stall.
    fwd_id_a   = m_rw_q && !m_mr_q && m_rs;
    fwd_id_b   = m_rw_q && !m_mr_q && m_rt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_dest_q    <= '0;
      e_rw_q      <= 1'b0;
      e_mr_q      <= 1'b0;
      m_dest_q    <= '0;
      m_rw_q      <= 1'b0;
      m_mr_q      <= 1'b0;
      fwd_a       <= 2'd0;
      fwd_b       <= 2'd0;
      stall_count <= '0;
    end else begin
      if (!stall && id_valid) begin
        e_dest_q <= id_dest;
        e_rw_q   <= id_reg_write;
        e_mr_q   <= id_mem_read;
      end else begin
        e_dest_q <= '0;
        e_rw_q   <= 1'b0;
        e_mr_q   <= 1'b0;
      end
      m_dest_q <= e_dest_q;
      m_rw_q   <= e_rw_q;
      m_mr_q   <= e_mr_q;
      fwd_a    <= fwd_a_d;
      fwd_b    <= fwd_b_d;
      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule
